// File: rtl/timer_pkg.sv
// Shared timer definitions: mode encodings and tick-generator FSM states.
package timer_pkg;

    typedef enum logic [1:0] {
        ModeStop   = 2'd0,
        ModeUp     = 2'd1,
        ModeDown   = 2'd2,
        ModeUpDown = 2'd3
    } timer_mode_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunUp   = 2'd1,
        StRunDown = 2'd2,
        StDone    = 2'd3
    } timer_state_e;

    // True while the generator is actively sweeping in either direction.
    function automatic logic is_running(timer_state_e st);
        return (st == StRunUp) || (st == StRunDown);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-(period+1) prescaler: counts run cycles and emits a tick on the last one.
module timer_prescaler #(
    parameter int unsigned PRESCALE_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     run,
    input  logic [PRESCALE_SIZE-1:0] period,
    output logic                     tick
);

    logic [PRESCALE_SIZE-1:0] count_q, count_d;

    assign tick = run && (count_q == period);

    // Next count: clear wins, otherwise advance while running and wrap on tick.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timer_tick_gen.sv
// Tick generator: issues up/down strobes to an external counter at a prescaled rate,
// with up, down and triangle sweeps in continuous or one-shot operation.
module timer_tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE  = 8,
    parameter int unsigned PRESCALE_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic                     one_shot,
    input  logic [PRESCALE_SIZE-1:0] prescale,
    input  logic [COUNTER_SIZE-1:0]  value,
    output logic                     up,
    output logic                     down,
    output logic                     busy,
    output logic                     done
);

    timer_state_e             state_q, state_d;
    timer_mode_e              mode_q, mode_d;
    logic                     one_shot_q, one_shot_d;
    logic [PRESCALE_SIZE-1:0] prescale_q, prescale_d;
    logic                     done_q, done_d;
    logic                     up_req, down_req;
    logic                     tick, run;
    logic                     value_max, value_min;

    assign busy      = is_running(state_q);
    assign run       = busy && enable;
    assign value_max = &value;
    assign value_min = ~|value;

    // Prescaler only advances in an enabled run state; anything else holds it at zero.
    timer_prescaler #(
        .PRESCALE_SIZE (PRESCALE_SIZE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (!run),
        .run    (run),
        .period (prescale_q),
        .tick   (tick)
    );

    // Next-state, settings latch and strobe decode.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        one_shot_d = one_shot_q;
        prescale_d = prescale_q;
        done_d     = 1'b0;
        up_req     = 1'b0;
        down_req   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && (timer_mode_e'(mode) != ModeStop)) begin
                    mode_d     = timer_mode_e'(mode);
                    one_shot_d = one_shot;
                    prescale_d = prescale;
                    state_d    = (timer_mode_e'(mode) == ModeDown) ? StRunDown : StRunUp;
                end
            end

            StRunUp: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (!value_max) begin
                        up_req = 1'b1;
                    end else if (mode_q == ModeUpDown) begin
                        // Top of the triangle: hold for one tick, then reverse.
                        state_d = StRunDown;
                    end else if (one_shot_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        up_req = 1'b1;
                    end
                end
            end

            StRunDown: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (!value_min) begin
                        down_req = 1'b1;
                    end else if (mode_q == ModeUpDown) begin
                        // Bottom of the triangle ends a full sweep.
                        if (one_shot_q) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRunUp;
                        end
                    end else if (one_shot_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        down_req = 1'b1;
                    end
                end
            end

            StDone: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // A reset cycle must not leak a strobe from the state being aborted.
    assign up   = up_req && rst;
    assign down = down_req && rst;
    assign done = done_q;

    // State, latched settings and done pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            mode_q     <= ModeStop;
            one_shot_q <= 1'b0;
            prescale_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            one_shot_q <= one_shot_d;
            prescale_q <= prescale_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_timer_tick_gen.sv
// Self-checking bench for timer_tick_gen with an attached behavioural counter.
module tb_timer_tick_gen;

    localparam int CW = 4;
    localparam int PW = 8;
    localparam int VMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [1:0]    mode;
    logic          one_shot;
    logic [PW-1:0] prescale;
    logic [CW-1:0] value;
    logic          up, down, busy, done;

    logic          attach, load;
    logic [CW-1:0] load_val, man_val, cnt;
    logic          check_en = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign value = attach ? cnt : man_val;

    timer_tick_gen #(
        .COUNTER_SIZE  (CW),
        .PRESCALE_SIZE (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode     (mode),
        .one_shot (one_shot),
        .prescale (prescale),
        .value    (value),
        .up       (up),
        .down     (down),
        .busy     (busy),
        .done     (done)
    );

    // Downstream counter driven by the strobes.
    always @(posedge clk) begin
        if (load) cnt <= load_val;
        else if (up) cnt <= cnt + 1'b1;
        else if (down) cnt <= cnt - 1'b1;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {PIdle, PUp, PDown, PDone} phase_t;
    phase_t ph = PIdle;
    phase_t nph;
    int     m_mode, m_os, m_p, since;
    bit     m_done = 1'b0;
    bit     nxt_done, exp_up, exp_down, exp_busy, tk;

    // Per cycle: derive expected outputs from the sweep rules, compare, then advance.
    always @(negedge clk) begin
        if (check_en) begin
            exp_up   = 1'b0;
            exp_down = 1'b0;
            exp_busy = (ph == PUp) || (ph == PDown);
            nxt_done = 1'b0;
            nph      = ph;
            if (!rst) begin
                nph = PIdle; m_mode = 0; m_os = 0; m_p = 0;
            end else begin
                case (ph)
                    PIdle: if (enable && mode != 2'd0) begin
                        m_mode = int'(mode); m_os = int'(one_shot); m_p = int'(prescale);
                        since  = 0;
                        nph    = (mode == 2'd2) ? PDown : PUp;
                    end
                    PUp, PDown: if (!enable) nph = PIdle;
                    else begin
                        since++;
                        tk = (since % (m_p + 1)) == 0;
                        if (tk && ph == PUp) begin
                            if (int'(value) != VMAX) exp_up = 1'b1;
                            else if (m_mode == 3) nph = PDown;
                            else if (m_os != 0) begin nph = PDone; nxt_done = 1'b1; end
                            else exp_up = 1'b1;
                        end else if (tk) begin
                            if (value != 0) exp_down = 1'b1;
                            else if (m_mode == 3 && m_os == 0) nph = PUp;
                            else if (m_os != 0) begin nph = PDone; nxt_done = 1'b1; end
                            else exp_down = 1'b1;
                        end
                    end
                    PDone: if (!enable) nph = PIdle;
                    default: nph = PIdle;
                endcase
            end
            check("model_up", int'(up), int'(exp_up));
            check("model_down", int'(down), int'(exp_down));
            check("model_busy", int'(busy), int'(exp_busy));
            check("model_done", int'(done), int'(m_done));
            ph     = nph;
            m_done = nxt_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic go(input logic [1:0] m, input logic os, input logic [PW-1:0] p);
        @(posedge clk); #1;
        mode = m; one_shot = os; prescale = p; enable = 1'b1;
        @(negedge clk); // last idle cycle; next negedge is the first run cycle
    endtask

    task automatic stop();
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_cnt(input logic [CW-1:0] v);
        @(posedge clk); #1;
        load = 1'b1; load_val = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    int n_up, n_dn, n_done, first_up, done_at, k, expv;

    initial begin
        rst = 1'b0; enable = 1'b0; mode = 2'd0; one_shot = 1'b0; prescale = '0;
        attach = 1'b0; load = 1'b0; load_val = '0; man_val = '0;
        @(posedge clk); #1;
        check_en = 1'b1;
        @(negedge clk);
        check("rst_up", int'(up), 0);
        check("rst_down", int'(down), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Mode 0 with enable stays idle.
        enable = 1'b1; mode = 2'd0;
        repeat (3) begin
            @(negedge clk);
            check("mode0_idle", int'(busy), 0);
        end
        stop();

        // Up, prescale 3: up on run cycles 4, 8, 12, 16.
        man_val = '0;
        go(2'd1, 1'b0, 8'd3);
        n_up = 0; n_dn = 0; first_up = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (up) begin n_up++; if (first_up == 0) first_up = i; end
            if (down) n_dn++;
        end
        check("up_p3_count", n_up, 4);
        check("up_p3_first", first_up, 4);
        check("up_p3_down", n_dn, 0);
        stop();

        // Triangle on a 4-bit counter from 0.
        load_cnt(4'd0);
        attach = 1'b1;
        go(2'd3, 1'b0, 8'd0);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            k = (i - 1) % 32;
            expv = (k <= 15) ? k : 31 - k;
            check("tri_value", int'(value), expv);
        end
        stop();

        // One-shot down from 5.
        load_cnt(4'd5);
        go(2'd2, 1'b1, 8'd0);
        n_dn = 0; n_done = 0; done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (down) n_dn++;
            if (done) begin n_done++; done_at = i; end
        end
        check("os_down_count", n_dn, 5);
        check("os_done_pulses", n_done, 1);
        check("os_done_cycle", done_at, 7);
        check("os_final_value", int'(cnt), 0);
        check("os_busy_after", int'(busy), 0);
        stop();
        attach = 1'b0;

        // Enable dropped when a tick is due.
        man_val = '0;
        go(2'd1, 1'b0, 8'd2);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        check("drop_no_up", int'(up), 0);
        @(negedge clk);
        check("drop_idle", int'(busy), 0);
        check("drop_no_done", int'(done), 0);
        @(posedge clk); #1;

        // Reset during run with a tick due every cycle.
        go(2'd1, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstrun_no_up", int'(up), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstrun_up", int'(up), 0);
        check("rstrun_busy", int'(busy), 0);
        check("rstrun_done", int'(done), 0);
        stop();

        // Prescale change mid-run is ignored until re-enable.
        go(2'd1, 1'b0, 8'd3);
        n_up = 0;
        repeat (2) begin @(negedge clk); if (up) n_up++; end
        @(posedge clk); #1;
        prescale = 8'd0;
        repeat (14) begin @(negedge clk); if (up) n_up++; end
        check("pchg_old_period", n_up, 4);
        @(posedge clk); #1;
        enable = 1'b0;
        go(2'd1, 1'b0, 8'd0);
        n_up = 0;
        repeat (8) begin @(negedge clk); if (up) n_up++; end
        check("pchg_new_period", n_up, 8);
        stop();

        // One-shot up starting at all-ones.
        man_val = 4'd15;
        go(2'd1, 1'b1, 8'd1);
        n_up = 0; done_at = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (up) n_up++;
            if (done) done_at = i;
        end
        check("osup_no_up", n_up, 0);
        check("osup_done_cycle", done_at, 3);
        stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
